traffic_light_xing: RTL and testbench
=====================================

// Module: traffic_light_xing
// PURPOSE
//  Parametrised N-approach intersection controller; next generation of the single-lamp R/G/Y controller.
//  Rotates green among N_DIR approaches with all-red clearance between phases.
//  Serves latched pedestrian requests with a WALK phase; supports a flashing-yellow fault/night mode.
//  Sits at top level; drives lamp outputs directly.
// PARAMETERS
//  N_DIR     2   number of approaches (>=2)
//  CNT_W     8   phase timer width
//  G_CYC     20  green duration, cycles (1..2^CNT_W)
//  Y_CYC     4   yellow duration, cycles (1..2^CNT_W)
//  AR_CYC    2   all-red clearance duration, cycles (1..2^CNT_W)
//  PED_CYC   10  walk duration, cycles (1..2^CNT_W)
//  FLASH_CYC 8   flash half-period, cycles (1..2^CNT_W)
// PORTS
//  clk    in   1                 clock, rising edge
//  rst    in   1                 asynchronous, active-high reset
//  pass   in   1                 pedestrian request, level or pulse, sampled every clk
//  flash  in   1                 flashing-yellow mode enable
//  R      out  N_DIR             red lamp per approach
//  G      out  N_DIR             green lamp per approach
//  Y      out  N_DIR             yellow lamp per approach
//  walk   out  1                 pedestrian walk lamp
//  dir    out  $clog2(N_DIR)     index of approach owning current/next green
// BEHAVIOUR
//  - Moore outputs decoded from registered state/dir; no input-to-output comb path.
//  - Reset: state=S_AR, dir=0, timer=AR_CYC-1, ped_req=0, flash_ph=0.
//    R=all 1, G=0, Y=0, walk=0.
//  - One-hot states: S_AR, S_G, S_Y, S_W, S_WC (post-walk all-red), S_FL.
//  - Timer: loaded with X_CYC-1 on state entry; decrements each cycle.
//    Transition fires in the cycle timer==0, so each state lasts exactly X_CYC cycles.
//  - Transitions:
//    S_AR -> S_G (if !ped_req), else S_W
//    S_G  -> S_Y
//    S_Y  -> S_AR, dir <= (dir==N_DIR-1) ? 0 : dir+1
//    S_W  -> S_WC
//    S_WC -> S_G
//  - Lamps:
//    S_G:      G[dir]=1, R=~G.
//    S_Y:      Y[dir]=1, R=~Y.
//    S_AR/S_WC: R=all 1.
//    S_W:      R=all 1, walk=1.
//  - ped_req: set on any clk with pass=1 and state!=S_W; cleared on S_AR->S_W transition.
//    Set wins if pass=1 in that same cycle (request re-latched for next cycle).
//    pass during S_W is ignored.
//  - Latency: pass at cycle t becomes visible to the FSM at t+1.
//    A request arriving during S_AR in its final cycle is not served until the next S_AR.
//  - Flash:
//    * flash=1 in any state: next cycle enters S_FL with timer=FLASH_CYC-1 and flash_ph=1.
//    * In S_FL: R=0, G=0, walk=0, Y=all flash_ph. flash_ph toggles and timer reloads when timer==0.
//    * flash=0 while in S_FL: next cycle S_AR, dir=0, ped_req cleared, timer=AR_CYC-1.
//  - Priority: rst > flash > normal transition.
//  - Reset mid-operation: immediate async return to reset values (lamps all red, walk=0).
// STRUCTURE
//  - define.v additions: state index macros (TLX_S_AR..TLX_S_FL), TLX_STATE_W=6, timer width default.
//  - Sub-module phase_timer (CNT_W): load, load_val, done(==0) outputs.
//    Instantiated once, driven by FSM.
//  - FSM, dir counter, ped_req and flash_ph stay in this module.
// TESTING (defaults unless stated; cycle 0 = first clk after rst deassert)
//  1. Reset release, no pass/flash -> R=2'b11 c0-1; G=2'b01 c2-21; Y=2'b01 c22-25;
//     R=2'b11 c26-27; G=2'b10 c28-47.
//  2. pass=1 for 1 cycle at c5 -> Y=2'b01 c22-25, AR c26-27, walk=1 c28-37,
//     AR c38-39, G=2'b10 c40; ped_req=0 after c27.
//  3. Wrap: after dir=1 green/yellow (c28-51) -> AR c52-53, G=2'b01 c54, dir=0.
//  4. flash=1 at c10 (mid green) -> c11 G=0, Y=2'b11 for 8 cycles then 2'b00 for 8;
//     flash=0 -> next cycle R=2'b11, dir=0, green dir0 after 2 cycles.
//  5. rst pulsed during walk (c30) -> outputs R=all 1, walk=0 without clock edge; pending ped_req lost.
//  6. N_DIR=3, G_CYC=Y_CYC=AR_CYC=1 -> G 001,Y 001,AR,G 010,... each exactly 1 cycle;
//     dir wraps 2->0.

Source files
------------

// File: rtl/traffic_light_xing_pkg.sv
// traffic_light_xing_pkg: shared state encoding for the intersection controller
package traffic_light_xing_pkg;
  localparam int STATE_W = 6;
  typedef enum logic [STATE_W-1:0] {
    S_AR = 6'b000001,
    S_G  = 6'b000010,
    S_Y  = 6'b000100,
    S_W  = 6'b001000,
    S_WC = 6'b010000,
    S_FL = 6'b100000
  } state_t;
endpackage

// File: rtl/traffic_light_xing_phase_timer.sv
// traffic_light_xing_phase_timer: loadable down-counter timing each phase
// Ports: clk, rst (async high), load/load_val reload the count, done is high while count==0
module traffic_light_xing_phase_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= RST_VAL;
    else cnt <= load ? load_val : cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/traffic_light_xing.sv
// traffic_light_xing: N-approach intersection controller with pedestrian walk and flash mode
// Ports: clk, rst (async high), pass (ped request), flash (flashing-yellow enable),
//        R/G/Y lamps per approach, walk lamp, dir = approach owning current/next green
module traffic_light_xing
  import traffic_light_xing_pkg::*;
#(
  parameter int N_DIR     = 2,
  parameter int CNT_W     = 8,
  parameter int G_CYC     = 20,
  parameter int Y_CYC     = 4,
  parameter int AR_CYC    = 2,
  parameter int PED_CYC   = 10,
  parameter int FLASH_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pass,
  input  logic                     flash,
  output logic [N_DIR-1:0]         R,
  output logic [N_DIR-1:0]         G,
  output logic [N_DIR-1:0]         Y,
  output logic                     walk,
  output logic [$clog2(N_DIR)-1:0] dir
);
  localparam int DIR_W = $clog2(N_DIR);
  localparam logic [CNT_W-1:0] G_LD  = CNT_W'(G_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LD = CNT_W'(AR_CYC - 1);
  localparam logic [CNT_W-1:0] W_LD  = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] FL_LD = CNT_W'(FLASH_CYC - 1);
  state_t state, state_nx;
  logic ped_req, flash_ph, load, done, fl_exit, served;
  logic [CNT_W-1:0] load_val;
  logic [N_DIR-1:0] lamp;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_AR;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == S_FL) state_nx = flash ? S_FL : S_AR;
    else if (flash) state_nx = S_FL;
    else if (done)
      case (state)
        S_AR:    state_nx = ped_req ? S_W : S_G;
        S_G:     state_nx = S_Y;
        S_Y:     state_nx = S_AR;
        S_W:     state_nx = S_WC;
        S_WC:    state_nx = S_G;
        default: state_nx = S_AR;
      endcase
  end
  // any state change reloads the timer, and so does expiry inside S_FL (half-period reload)
  assign load     = done || state_nx != state;
  assign load_val = state_nx == S_G  ? G_LD :
                    state_nx == S_Y  ? Y_LD :
                    state_nx == S_W  ? W_LD :
                    state_nx == S_FL ? FL_LD : AR_LD;
  traffic_light_xing_phase_timer #(.CNT_W(CNT_W), .RST_VAL(AR_LD)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .done(done)
  );
  assign fl_exit = state == S_FL && !flash;
  assign served  = state == S_AR && state_nx == S_W;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir      <= '0;
      ped_req  <= 1'b0;
      flash_ph <= 1'b0;
    end else begin
      dir      <= fl_exit ? '0 :
                  (state == S_Y && state_nx == S_AR) ? (dir == DIR_W'(N_DIR - 1) ? '0 : dir + 1'b1) : dir;
      // a new request in the same cycle as the clear is kept
      ped_req  <= (pass && state != S_W) || (ped_req && !served && !fl_exit);
      flash_ph <= state_nx != S_FL ? 1'b0 : state != S_FL ? 1'b1 : done ? ~flash_ph : flash_ph;
    end
  always_comb begin
    lamp = {{(N_DIR-1){1'b0}}, 1'b1} << dir;
    G    = state == S_G ? lamp : '0;
    Y    = state == S_Y ? lamp : state == S_FL ? {N_DIR{flash_ph}} : '0;
    R    = state == S_FL ? '0 : ~(G | Y);
    walk = state == S_W;
  end
endmodule

// File: tb/tb_traffic_light_xing.sv
// tb_traffic_light_xing: randomized and directed checks against a phase/countdown reference model
module tb_traffic_light_xing;
  localparam int N = 2;
  localparam int P_AR = 0, P_G = 1, P_Y = 2, P_W = 3, P_WC = 4, P_FL = 5;
  logic clk = 0, rst = 1, pass = 0, flash = 0;
  logic [1:0] r, g, y, r3_unused;
  logic walk;
  logic [0:0] dir;
  logic [2:0] r3, g3, y3;
  logic walk3;
  logic [1:0] dir3;
  int n_checks = 0, n_fail = 0, k = 0;
  int m_ph, m_left, m_dir;
  bit m_req, m_fph;

  traffic_light_xing u_dut (
    .clk(clk), .rst(rst), .pass(pass), .flash(flash),
    .R(r), .G(g), .Y(y), .walk(walk), .dir(dir)
  );
  traffic_light_xing #(.N_DIR(3), .G_CYC(1), .Y_CYC(1), .AR_CYC(1)) u_dut3 (
    .clk(clk), .rst(rst), .pass(1'b0), .flash(1'b0),
    .R(r3), .G(g3), .Y(y3), .walk(walk3), .dir(dir3)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    return p == P_G ? 20 : p == P_Y ? 4 : p == P_W ? 10 : p == P_FL ? 8 : 2;
  endfunction

  task automatic model_reset();
    m_ph = P_AR; m_left = dur(P_AR); m_dir = 0; m_req = 0; m_fph = 0;
  endtask

  // m_left counts the cycles still to spend in the current phase, including this one
  task automatic model_step(input bit p, input bit f);
    bit nr, served, fexit;
    nr     = p && m_ph != P_W;
    fexit  = m_ph == P_FL && !f;
    served = !f && m_ph == P_AR && m_left == 1 && m_req;
    m_req  = nr || (m_req && !served && !fexit);
    if (m_ph == P_FL) begin
      if (!f) begin m_ph = P_AR; m_left = dur(P_AR); m_dir = 0; end
      else if (m_left == 1) begin m_left = dur(P_FL); m_fph = !m_fph; end
      else m_left--;
    end else if (f) begin
      m_ph = P_FL; m_left = dur(P_FL); m_fph = 1;
    end else if (m_left > 1) m_left--;
    else begin
      case (m_ph)
        P_AR: m_ph = served ? P_W : P_G;
        P_G:  m_ph = P_Y;
        P_Y:  begin m_ph = P_AR; m_dir = (m_dir + 1) % N; end
        P_W:  m_ph = P_WC;
        default: m_ph = P_G;
      endcase
      m_left = dur(m_ph);
    end
  endtask

  // {R, G, Y, walk, dir}
  function automatic logic [7:0] exp_out();
    logic [1:0] eg, ey, er;
    eg = 0; ey = 0;
    if (m_ph == P_G) eg[m_dir] = 1'b1;
    if (m_ph == P_Y) ey[m_dir] = 1'b1;
    if (m_ph == P_FL) ey = {2{m_fph}};
    er = m_ph == P_FL ? 2'b00 : ~(eg | ey);
    return {er, eg, ey, m_ph == P_W, 1'(m_dir)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; pass = 0; flash = 0;
    model_reset();
    @(negedge clk);
    rst = 0; k = 0;
  endtask

  task automatic step(input logic p, input logic f);
    pass = p; flash = f;
    @(posedge clk);
    model_step(p, f);
    @(negedge clk);
    k++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++;
    if ({r, g, y, walk, dir} !== 8'b11_00_00_0_0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", {r, g, y, walk, dir}, 8'b11000000);
    end
    do_reset();
  endtask

  task automatic test_normal_wrap();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      n_checks++;
      if ({r, g, y, walk, dir} !== exp_out()) begin
        n_fail++; $display("FAIL normal k=%0d got=%b want=%b", k, {r, g, y, walk, dir}, exp_out());
      end
      if (k == 1 || k == 2 || k == 22 || k == 28 || k == 53 || k == 54) begin
        n_checks++;
        if ((k == 1 && r !== 2'b11) || (k == 2 && g !== 2'b01) || (k == 22 && y !== 2'b01) ||
            (k == 28 && g !== 2'b10) || (k == 53 && (r !== 2'b11 || dir !== 1'b0)) ||
            (k == 54 && g !== 2'b01)) begin
          n_fail++; $display("FAIL timeline k=%0d got R=%b G=%b Y=%b dir=%0d", k, r, g, y, dir);
        end
      end
      step(0, 0);
    end
  endtask

  task automatic test_ped();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      n_checks++;
      if ({r, g, y, walk, dir} !== exp_out()) begin
        n_fail++; $display("FAIL ped k=%0d got=%b want=%b", k, {r, g, y, walk, dir}, exp_out());
      end
      if (k == 27 || k == 28 || k == 37 || k == 38 || k == 40) begin
        n_checks++;
        if ((k == 27 && walk !== 1'b0) || (k == 28 && (walk !== 1'b1 || r !== 2'b11)) ||
            (k == 37 && walk !== 1'b1) || (k == 38 && walk !== 1'b0) || (k == 40 && g !== 2'b10)) begin
          n_fail++; $display("FAIL ped_timeline k=%0d got walk=%b R=%b G=%b", k, walk, r, g);
        end
      end
      step(k == 5, 0);
    end
  endtask

  task automatic test_flash();
    do_reset();
    for (int i = 0; i < 36; i++) begin
      n_checks++;
      if ({r, g, y, walk, dir} !== exp_out()) begin
        n_fail++; $display("FAIL flash k=%0d got=%b want=%b", k, {r, g, y, walk, dir}, exp_out());
      end
      if (k == 11 || k == 18 || k == 19 || k == 27 || k == 31 || k == 33) begin
        n_checks++;
        if ((k == 11 && {r, g, y} !== 6'b00_00_11) || (k == 18 && y !== 2'b11) ||
            (k == 19 && {r, y} !== 4'b0000) || (k == 27 && y !== 2'b11) ||
            (k == 31 && (r !== 2'b11 || dir !== 1'b0)) || (k == 33 && g !== 2'b01)) begin
          n_fail++; $display("FAIL flash_timeline k=%0d got R=%b G=%b Y=%b dir=%0d", k, r, g, y, dir);
        end
      end
      step(0, k >= 10 && k <= 29);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    while (k < 30) step(k == 5, 0);
    n_checks++;
    if (walk !== 1'b1) begin
      n_fail++; $display("FAIL walk_before_rst got=%b want=1", walk);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({r, g, y, walk} !== 7'b11_00_00_0) begin
      n_fail++; $display("FAIL async_rst got=%b want=%b", {r, g, y, walk}, 7'b1100000);
    end
    model_reset();
    @(negedge clk);
    rst = 0; k = 0;
    for (int i = 0; i < 45; i++) begin
      n_checks++;
      if ({r, g, y, walk, dir} !== exp_out()) begin
        n_fail++; $display("FAIL post_rst k=%0d got=%b want=%b", k, {r, g, y, walk, dir}, exp_out());
      end
      step(k == 1, 0);
    end
  endtask

  task automatic test_random();
    logic f;
    f = 0;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      n_checks++;
      if ({r, g, y, walk, dir} !== exp_out()) begin
        n_fail++; $display("FAIL random k=%0d got=%b want=%b", k, {r, g, y, walk, dir}, exp_out());
      end
      if ($urandom_range(0, 59) == 0) f = ~f;
      step($urandom_range(0, 7) == 0, f);
    end
  endtask

  task automatic test_small();
    logic [2:0] eg, ey;
    int ph, d;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      ph = n % 3; d = (n / 3) % 3;
      eg = ph == 1 ? 3'(1 << d) : 3'b000;
      ey = ph == 2 ? 3'(1 << d) : 3'b000;
      n_checks++;
      if ({r3, g3, y3, walk3, dir3} !== {~(eg | ey), eg, ey, 1'b0, 2'(d)}) begin
        n_fail++;
        $display("FAIL small n=%0d got R=%b G=%b Y=%b walk=%b dir=%0d want G=%b Y=%b dir=%0d",
                 n, r3, g3, y3, walk3, dir3, eg, ey, d);
      end
      step(0, 0);
    end
  endtask

  initial begin
    r3_unused = 0;
    model_reset();
    test_reset();
    test_normal_wrap();
    test_ped();
    test_flash();
    test_async_reset();
    test_random();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
